// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: gates the BCD counter enable, issues the counter clear,
// saturates at 59.9 and provides lap-freeze display registers.
module stopwatch_ctrl (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       btn_ss_i,
  input  logic       btn_lr_i,
  input  logic [3:0] cnt_ds_i,
  input  logic [3:0] cnt_ss_i,
  input  logic [2:0] cnt_ts_i,
  output logic       cnt_enable_o,
  output logic       cnt_clear_o,
  output logic [3:0] disp_ds_o,
  output logic [3:0] disp_ss_o,
  output logic [2:0] disp_ts_o,
  output logic       running_o,
  output logic       frozen_o,
  output logic       full_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    LAP  = 3'd2,
    STOP = 3'd3,
    FULL = 3'd4,
    CLR  = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       running_q, frozen_q, full_q, clr_q;
  logic [3:0] fz_ds_q, fz_ss_q;
  logic [2:0] fz_ts_q;
  logic       at_max;

  assign at_max = (cnt_ts_i == 3'd5) && (cnt_ss_i == 4'd9) && (cnt_ds_i == 4'd9);

  // Saturation on a tick outranks both buttons; start/stop outranks lap/reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (btn_ss_i) state_d = RUN;
      RUN: begin
        if (tick_i && at_max) state_d = FULL;
        else if (btn_ss_i)    state_d = STOP;
        else if (btn_lr_i)    state_d = LAP;
      end
      LAP: begin
        if (tick_i && at_max) state_d = FULL;
        else if (btn_ss_i)    state_d = STOP;
        else if (btn_lr_i)    state_d = RUN;
      end
      STOP: begin
        if (btn_ss_i)      state_d = RUN;
        else if (btn_lr_i) state_d = CLR;
      end
      FULL: if (btn_lr_i) state_d = CLR;
      CLR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
      full_q    <= 1'b0;
      clr_q     <= 1'b0;
      fz_ds_q   <= 4'd0;
      fz_ss_q   <= 4'd0;
      fz_ts_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN) || (state_d == LAP);
      frozen_q  <= (state_d == LAP);
      full_q    <= (state_d == FULL);
      clr_q     <= (state_d == CLR);
      if (state_q == RUN && state_d == LAP) begin
        fz_ds_q <= cnt_ds_i;
        fz_ss_q <= cnt_ss_i;
        fz_ts_q <= cnt_ts_i;
      end
    end
  end

  assign cnt_enable_o = tick_i & running_q & ~at_max & reset_i;
  assign cnt_clear_o  = clr_q | ~reset_i;

  assign disp_ds_o = frozen_q ? fz_ds_q : cnt_ds_i;
  assign disp_ss_o = frozen_q ? fz_ss_q : cnt_ss_i;
  assign disp_ts_o = frozen_q ? fz_ts_q : cnt_ts_i;

  assign running_o = running_q;
  assign frozen_o  = frozen_q;
  assign full_o    = full_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a behavioural BCD counter closes the loop
// and a per-cycle reference model feeds a scoreboard queue of expected outputs.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3, M_FULL = 4, M_CLR = 5;

  typedef struct packed {
    logic        en;
    logic        clr;
    logic [2:0]  flags;
    logic [10:0] disp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, btnSs = 1'b0, btnLr = 1'b0;
  logic [3:0] cntDs = 4'd0, cntSs = 4'd0;
  logic [2:0] cntTs = 3'd0;
  logic       cntEnable, cntClear, running, frozen, full;
  logic [3:0] dispDs, dispSs;
  logic [2:0] dispTs;

  exp_t sbQ[$];
  int   errorCount = 0;
  int   checkCount = 0;
  int   enableCount = 0;
  int   clearCount = 0;
  bit   modelValid = 0;

  int          mState = M_IDLE;
  logic [10:0] mFz = '0;

  logic        obsEn, obsClr;
  logic [2:0]  obsFlags;
  logic [10:0] obsDisp;

  stopwatch_ctrl dut (
    .clk_i(clk), .reset_i(reset), .tick_i(tick), .btn_ss_i(btnSs), .btn_lr_i(btnLr),
    .cnt_ds_i(cntDs), .cnt_ss_i(cntSs), .cnt_ts_i(cntTs),
    .cnt_enable_o(cntEnable), .cnt_clear_o(cntClear),
    .disp_ds_o(dispDs), .disp_ss_o(dispSs), .disp_ts_o(dispTs),
    .running_o(running), .frozen_o(frozen), .full_o(full)
  );

  always #5 clk = ~clk;

  // Counter datapath the controller drives, wrapping 59.9 -> 00.0 if enabled there.
  always @(posedge clk) begin
    if (cntClear) begin
      cntDs <= 4'd0; cntSs <= 4'd0; cntTs <= 3'd0;
    end else if (cntEnable) begin
      if (cntDs == 4'd9) begin
        cntDs <= 4'd0;
        if (cntSs == 4'd9) begin
          cntSs <= 4'd0;
          cntTs <= (cntTs == 3'd5) ? 3'd0 : cntTs + 3'd1;
        end else cntSs <= cntSs + 4'd1;
      end else cntDs <= cntDs + 4'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic ss, input logic lr, input logic tk);
    exp_t e;
    logic atMax, mRun;
    int   nxt;
    @(posedge clk); #1;
    reset = rstN; btnSs = ss; btnLr = lr; tick = tk;
    atMax   = (cntTs == 3'd5) && (cntSs == 4'd9) && (cntDs == 4'd9);
    mRun    = (mState == M_RUN) || (mState == M_LAP);
    e.en    = tk && mRun && !atMax && rstN;
    e.clr   = (mState == M_CLR) || !rstN;
    e.flags = {mRun, mState == M_LAP, mState == M_FULL};
    e.disp  = (mState == M_LAP) ? mFz : {cntTs, cntSs, cntDs};
    sbQ.push_back(e);
    @(negedge clk);
    e = sbQ.pop_front();
    obsEn = cntEnable; obsClr = cntClear;
    obsFlags = {running, frozen, full};
    obsDisp = {dispTs, dispSs, dispDs};
    if (modelValid) begin
      checkOutput("cnt_enable", {31'd0, obsEn}, {31'd0, e.en});
      checkOutput("cnt_clear", {31'd0, obsClr}, {31'd0, e.clr});
      checkOutput("status", {29'd0, obsFlags}, {29'd0, e.flags});
      checkOutput("display", {21'd0, obsDisp}, {21'd0, e.disp});
    end
    if (obsEn) enableCount++;
    if (obsClr) clearCount++;
    nxt = mState;
    if (!rstN) begin
      nxt = M_IDLE;
      mFz = '0;
    end else if (mState == M_IDLE) begin
      if (ss) nxt = M_RUN;
    end else if (mState == M_RUN || mState == M_LAP) begin
      if (tk && atMax) nxt = M_FULL;
      else if (ss) nxt = M_STOP;
      else if (lr) begin
        if (mState == M_RUN) mFz = {cntTs, cntSs, cntDs};
        nxt = (mState == M_RUN) ? M_LAP : M_RUN;
      end
    end else if (mState == M_STOP) begin
      if (ss) nxt = M_RUN;
      else if (lr) nxt = M_CLR;
    end else if (mState == M_FULL) begin
      if (lr) nxt = M_CLR;
    end else begin
      nxt = M_IDLE;
    end
    mState = nxt;
    modelValid = 1;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 0, 0);
    end
  endtask

  task automatic runTo(input logic [10:0] target);
    int n = 0;
    while ({cntTs, cntSs, cntDs} != target && n < 1500) begin
      runTicks(1);
      n++;
    end
    checkOutput("reach_target", {21'd0, cntTs, cntSs, cntDs}, {21'd0, target});
  endtask

  initial begin
    // Reset then run
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("clear_in_reset", {31'd0, obsClr}, 32'd1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("run_after_ss", {29'd0, obsFlags}, 32'b100);
    enableCount = 0;
    runTicks(25);
    checkOutput("enable_pulses", enableCount, 25);
    checkOutput("count_02_5", {21'd0, cntTs, cntSs, cntDs}, {21'd0, 3'd0, 4'd2, 4'd5});

    // Lap freeze
    runTo({3'd0, 4'd3, 4'd7});
    applyStimulus(1, 0, 1, 0);
    runTicks(10);
    checkOutput("lap_disp", {21'd0, obsDisp}, {21'd0, 3'd0, 4'd3, 4'd7});
    checkOutput("lap_count", {21'd0, cntTs, cntSs, cntDs}, {21'd0, 3'd0, 4'd4, 4'd7});
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("unlap_disp", {21'd0, obsDisp}, {21'd0, 3'd0, 4'd4, 4'd7});
    checkOutput("unlap_frozen", {31'd0, obsFlags[1]}, 32'd0);

    // Stop and clear
    runTo({3'd1, 4'd2, 4'd3});
    applyStimulus(1, 1, 0, 0);
    enableCount = 0;
    runTicks(5);
    checkOutput("stop_hold", {21'd0, cntTs, cntSs, cntDs}, {21'd0, 3'd1, 4'd2, 4'd3});
    checkOutput("stop_no_enable", enableCount, 0);
    applyStimulus(1, 0, 1, 0);
    clearCount = 0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("clear_pulse_len", clearCount, 1);
    checkOutput("clear_disp", {21'd0, obsDisp}, 32'd0);
    checkOutput("clear_status", {29'd0, obsFlags}, 32'd0);

    // Saturation
    applyStimulus(1, 1, 0, 0);
    runTo({3'd5, 4'd9, 4'd9});
    applyStimulus(1, 0, 0, 1);
    checkOutput("sat_enable", {31'd0, obsEn}, 32'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("full_set", {29'd0, obsFlags}, 32'b001);
    checkOutput("sat_hold", {21'd0, cntTs, cntSs, cntDs}, {21'd0, 3'd5, 4'd9, 4'd9});
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("full_ignores_ss", {29'd0, obsFlags}, 32'b001);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("full_to_clr", {31'd0, obsClr}, 32'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("full_cleared", {21'd0, obsDisp}, 32'd0);

    // Simultaneous buttons and tick in RUN
    applyStimulus(1, 1, 0, 0);
    runTo({3'd0, 4'd5, 4'd0});
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("simul_counted", {21'd0, cntTs, cntSs, cntDs}, {21'd0, 3'd0, 4'd5, 4'd1});
    checkOutput("simul_stop", {29'd0, obsFlags}, 32'd0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stop_tick_ignored", {21'd0, cntTs, cntSs, cntDs}, {21'd0, 3'd0, 4'd5, 4'd1});

    // Reset mid-lap
    applyStimulus(1, 1, 0, 0);
    runTo({3'd0, 4'd7, 4'd2});
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("in_lap", {29'd0, obsFlags}, 32'b110);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_status", {29'd0, obsFlags}, 32'd0);
    checkOutput("rst_clear", {31'd0, obsClr}, 32'd1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst_count", {21'd0, cntTs, cntSs, cntDs}, 32'd0);
    checkOutput("rst_disp", {21'd0, obsDisp}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
